counter_4b: RTL and testbench
=============================

// Module: counter_4b
// PURPOSE
//   Synchronous up/down counter, WIDTH bits (default 4), with four operating modes.
//   Modes are count up by 3, count down by 1, count up by 1 and parallel load.
//   Produces a ripple-carry-out (rco) flag on wrap-around and a load-acknowledge flag.
//   Used as a scoreboard/reference counter and as a cascadable counting stage.
// PARAMETERS
//   WIDTH  4  counter width in bits; Q and D are WIDTH bits wide.
// PORTS
//   clk     in   1      clock; all state updates on the rising edge.
//   reset   in   1      asynchronous, active-low reset (0 = reset).
//   enable  in   1      1 = the counter operates per mode; 0 = Q holds.
//   mode    in   2      operation select; see BEHAVIOUR.
//   D       in   WIDTH  parallel-load value, used in mode 2'b11.
//   Q       out  WIDTH  registered count value.
//   rco     out  1      registered flag: high one cycle when the count wraps.
//   load    out  1      registered flag: high one cycle when D was loaded.
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is asynchronous, active-low.
//   - While reset=0: Q=0, rco=0, load=0 immediately, independent of clk.
//     * Takes effect mid-operation too.
//     * The first count occurs on the first rising edge after reset returns to 1.
//   - All outputs are registered. The new value is visible after the edge (latency 1 clk).
//   - enable=0: Q holds, and rco=0 and load=0 on each edge. mode and D are ignored.
//   - enable=1, action on each rising edge by mode (arithmetic is modulo 2^WIDTH):
//     * 2'b00: Q <= Q+3. rco=1 if Q+3 > 2^WIDTH-1 (wrap, e.g. 14 -> 1), else 0.
//     * 2'b01: Q <= Q-1. rco=1 if Q==0 (wrap 0 -> 15), else 0.
//     * 2'b10: Q <= Q+1. rco=1 if Q==2^WIDTH-1 (wrap 15 -> 0), else 0.
//     * 2'b11: Q <= D. load=1 and rco=0.
//   - In any mode other than 2'b11, load=0.
//   - rco and load are single-cycle pulses per edge. They stay high on consecutive
//     edges only if the condition repeats, e.g. continuous loads.
//   - rco and load are never high on the same cycle.
//   - mode and D are sampled only at the rising edge. Changes between edges have no effect.
//   - No X propagation: every output is defined from reset onward.
// TESTING
//   1. Reset: assert reset=0 mid-count with Q=9
//      -> Q=0, rco=0, load=0 immediately.
//      Release, enable=1, mode=10 -> Q=1 after the first edge.
//   2. Up by 1: mode=10, start Q=0, 16 edges
//      -> Q=1..15,0, and rco=1 only on the 15->0 edge.
//   3. Down by 1: mode=01 from Q=2
//      -> Q=1,0,15,14, and rco=1 only on the 0->15 edge.
//   4. Up by 3: mode=00 from Q=9
//      -> Q=12,15,2,5, and rco=1 only on the 15->2 edge.
//   5. Load: mode=11, D=4'hA -> Q=10, load=1, rco=0.
//      Next edge with mode=10 -> Q=11, load=0.
//   6. Hold: enable=0 with Q=7, mode=00, D=3, for 5 edges
//      -> Q=7, rco=0, load=0 throughout.
//      Random mode/D/enable for 100 cycles with results matching a behavioural model.

Source files
------------

// File: rtl/counter_4b_if.sv
// Purpose : Bundles the control, load-data and status signals of counter_4b.
//   master : drives enable/mode/D, observes Q/rco/load (stimulus side)
//   slave  : consumes enable/mode/D, drives Q/rco/load (counter side)
// Signals:
//   enable  1      1 = count per mode, 0 = hold
//   mode    2      00 up by 3, 01 down by 1, 10 up by 1, 11 parallel load
//   D       WIDTH  parallel-load value
//   Q       WIDTH  registered count
//   rco     1      registered wrap pulse
//   load    1      registered load-acknowledge pulse
interface counter_4b_if #(
   parameter int unsigned WIDTH = 4
);
   logic             enable;
   logic [1:0]       mode;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             rco;
   logic             load;

   modport master (
      output enable, mode, D,
      input  Q, rco, load
   );

   modport slave (
      input  enable, mode, D,
      output Q, rco, load
   );
endinterface

// File: rtl/counter_4b.sv
// Purpose : WIDTH-bit up/down counter with four modes (up 3, down 1, up 1,
//           parallel load), a registered wrap flag and a load acknowledge.
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset (clears Q, rco, load)
//   bus    slave modport of counter_4b_if (enable, mode, D in; Q, rco, load out)
module counter_4b #(
   parameter int unsigned WIDTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   counter_4b_if.slave  bus
);

   typedef enum logic [1:0] {
      MODE_UP3  = 2'b00,
      MODE_DN1  = 2'b01,
      MODE_UP1  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   logic [WIDTH-1:0] r_q;
   logic             r_rco;
   logic             r_load;

   logic [WIDTH:0]   w_up3;
   logic [WIDTH:0]   w_up1;
   logic [WIDTH:0]   w_dn1;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_rco_nxt;
   logic             w_load_nxt;
   mode_t            w_mode;

   // One extra bit on each result exposes the wrap as a carry/borrow.
   assign w_up3  = {1'b0, r_q} + (WIDTH+1)'(3);
   assign w_up1  = {1'b0, r_q} + (WIDTH+1)'(1);
   assign w_dn1  = {1'b0, r_q} - (WIDTH+1)'(1);
   assign w_mode = mode_t'(bus.mode);

   always_comb begin
      w_q_nxt    = r_q;
      w_rco_nxt  = 1'b0;
      w_load_nxt = 1'b0;
      if (bus.enable) begin
         unique case (w_mode)
            MODE_UP3: begin
               w_q_nxt   = w_up3[WIDTH-1:0];
               w_rco_nxt = w_up3[WIDTH];
            end
            MODE_DN1: begin
               w_q_nxt   = w_dn1[WIDTH-1:0];
               w_rco_nxt = w_dn1[WIDTH];
            end
            MODE_UP1: begin
               w_q_nxt   = w_up1[WIDTH-1:0];
               w_rco_nxt = w_up1[WIDTH];
            end
            MODE_LOAD: begin
               w_q_nxt    = bus.D;
               w_load_nxt = 1'b1;
            end
            default: begin
               w_q_nxt = r_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q    <= '0;
         r_rco  <= 1'b0;
         r_load <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_rco  <= w_rco_nxt;
         r_load <= w_load_nxt;
      end
   end

   assign bus.Q    = r_q;
   assign bus.rco  = r_rco;
   assign bus.load = r_load;

endmodule

// File: tb/tb_counter_4b.sv
// Purpose : Self-checking bench for counter_4b. Directed sequences for reset,
//           each mode, load and hold, then randomized traffic compared with an
//           integer-arithmetic reference model.
module tb_counter_4b;

   localparam int unsigned WIDTH = 4;
   localparam int          MODV  = 1 << WIDTH;

   logic clk;
   logic reset;

   counter_4b_if #(.WIDTH(WIDTH)) u_if ();

   counter_4b #(.WIDTH(WIDTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   int n_cmp;
   int n_mis;
   int m_q;   // reference count value

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Waits for the next rising edge with inputs already applied, advances the
   // reference model, then checks all outputs just after the edge.
   task automatic edge_check(input string tag);
      int en, md, d, nq, e_rco, e_load;
      en = int'(u_if.enable);
      md = int'(u_if.mode);
      d  = int'(u_if.D);
      @(posedge clk);
      e_rco  = 0;
      e_load = 0;
      nq     = m_q;
      if (en == 1) begin
         case (md)
            0: nq = m_q + 3;
            1: nq = m_q - 1;
            2: nq = m_q + 1;
            default: begin nq = d; e_load = 1; end
         endcase
         if (md != 3 && (nq < 0 || nq >= MODV)) e_rco = 1;
      end
      m_q = (nq + MODV) % MODV;
      #1;
      chk({tag, ".Q"},    int'(u_if.Q),    m_q);
      chk({tag, ".rco"},  int'(u_if.rco),  e_rco);
      chk({tag, ".load"}, int'(u_if.load), e_load);
   endtask

   task automatic step(input string tag, input logic en, input logic [1:0] md,
                       input logic [WIDTH-1:0] d);
      @(negedge clk);
      u_if.enable = en;
      u_if.mode   = md;
      u_if.D      = d;
      edge_check(tag);
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      m_q   = 0;
      reset       = 1'b0;
      u_if.enable = 1'b0;
      u_if.mode   = 2'b00;
      u_if.D      = '0;
      #3;
      chk("por.Q",    int'(u_if.Q),    0);
      chk("por.rco",  int'(u_if.rco),  0);
      chk("por.load", int'(u_if.load), 0);
      @(negedge clk);
      reset = 1'b1;

      // Reset mid-operation from Q=9, asynchronous to the clock
      step("ld9", 1'b1, 2'b11, 4'd9);
      #2 reset = 1'b0;
      #1;
      m_q = 0;
      chk("arst.Q",    int'(u_if.Q),    0);
      chk("arst.rco",  int'(u_if.rco),  0);
      chk("arst.load", int'(u_if.load), 0);
      @(negedge clk);
      reset       = 1'b1;
      u_if.enable = 1'b1;
      u_if.mode   = 2'b10;
      edge_check("rel");

      // Up by 1 from 0 across the full range
      step("to0", 1'b1, 2'b01, '0);
      for (int i = 0; i < 16; i++) step("up1", 1'b1, 2'b10, '0);

      // Down by 1 from 2
      step("ld2", 1'b1, 2'b11, 4'd2);
      for (int i = 0; i < 4; i++) step("dn1", 1'b1, 2'b01, '0);

      // Up by 3 from 9
      step("ld9b", 1'b1, 2'b11, 4'd9);
      for (int i = 0; i < 4; i++) step("up3", 1'b1, 2'b00, '0);

      // Load then count
      step("ldA", 1'b1, 2'b11, 4'hA);
      step("ldA+1", 1'b1, 2'b10, 4'h5);
      step("ld2x", 1'b1, 2'b11, 4'hF);
      step("ld2y", 1'b1, 2'b11, 4'h3);

      // Hold
      step("ld7", 1'b1, 2'b11, 4'd7);
      for (int i = 0; i < 5; i++) step("hold", 1'b0, 2'b00, 4'd3);

      // Random traffic; inputs are also scrambled between edges
      for (int i = 0; i < 100; i++) begin
         step("rnd", ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, MODV - 1)));
         #1;
         u_if.mode = 2'($urandom_range(0, 3));
         u_if.D    = WIDTH'($urandom_range(0, MODV - 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
